button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 98 +++++++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: synchronizer, shared sample tick, per-channel saturating debounce counter, edge pulses.
// Optional release filtering (hysteresis) enabled by defining BUTTON_CONDITIONER_FALL_FILTER_EN.
module button_conditioner #(
    parameter int WIDTH            = 1,
    parameter int SAMPLE_COUNT_MAX = 25000,
    parameter int PULSE_COUNT_MAX  = 150,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int SCW = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
    localparam int PCW = $clog2(PULSE_COUNT_MAX + 1);
    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_COUNT_MAX - 1);
    localparam logic [PCW-1:0] PULSE_FULL  = PCW'(PULSE_COUNT_MAX);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [SCW-1:0]   sample_cnt;
    logic             sample_tick;
    logic [PCW-1:0]   cnt_q [WIDTH];
    logic [PCW-1:0]   cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= glitchy_signal;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Shared prescaler; with SAMPLE_COUNT_MAX=1 it sits at 0 and ticks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (sample_cnt == SAMPLE_LAST) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SCW'(1);
        end
    end

    assign sample_tick = (sample_cnt == SAMPLE_LAST);

    always_comb begin
        cnt_d = cnt_q;
        deb_d = debounced_signal;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef BUTTON_CONDITIONER_FALL_FILTER_EN
            if (sample_tick) begin
                if (sync[i]) begin
                    if (cnt_q[i] != PULSE_FULL) cnt_d[i] = cnt_q[i] + PCW'(1);
                end else begin
                    if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - PCW'(1);
                end
            end
            // Output only moves at the rails; in between it holds (hysteresis).
            if (cnt_d[i] == PULSE_FULL) begin
                deb_d[i] = 1'b1;
            end else if (cnt_d[i] == '0) begin
                deb_d[i] = 1'b0;
            end
`else
            if (!sync[i]) begin
                cnt_d[i] = '0;
            end else if (sample_tick && (cnt_q[i] != PULSE_FULL)) begin
                cnt_d[i] = cnt_q[i] + PCW'(1);
            end
            deb_d[i] = (cnt_d[i] == PULSE_FULL);
`endif
        end
    end

    // Pulses are derived from the next/current level pair so they line up with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            debounced_signal <= '0;
            rise_pulse       <= '0;
            fall_pulse       <= '0;
        end else begin
            cnt_q            <= cnt_d;
            debounced_signal <= deb_d;
            rise_pulse       <= deb_d & ~debounced_signal;
            fall_pulse       <= ~deb_d & debounced_signal;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random stimulus against a behavioural model.
module tb_button_conditioner;

    localparam int W   = 2;
    localparam int SCM = 10;
    localparam int PCM = 5;
    localparam int SS  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] glitchy_signal = '0;
    logic [W-1:0] debounced_signal;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural model state
    logic [W-1:0] raw_hist[$];
    int           m_cnt[W];
    logic [W-1:0] m_deb, m_rise, m_fall;
    int           m_edges;

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH(W), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .glitchy_signal(glitchy_signal),
        .debounced_signal(debounced_signal),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    task automatic model_reset();
        raw_hist.delete();
        for (int s = 0; s < SS; s++) raw_hist.push_front('0);
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
        m_deb   = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_edges = 0;
    endtask

    // One clock edge of the reference: the input seen is the raw value SS edges ago,
    // and every SCM-th edge after reset is a sample edge.
    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] seen;
        logic [W-1:0] prev;
        bit           tick;
        seen = raw_hist.pop_back();
        raw_hist.push_front(raw);
        m_edges++;
        tick = (m_edges % SCM) == 0;
        prev = m_deb;
        for (int i = 0; i < W; i++) begin
`ifdef BUTTON_CONDITIONER_FALL_FILTER_EN
            if (tick) m_cnt[i] = seen[i] ? ((m_cnt[i] < PCM) ? m_cnt[i] + 1 : PCM)
                                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (m_cnt[i] == PCM) m_deb[i] = 1'b1;
            else if (m_cnt[i] == 0) m_deb[i] = 1'b0;
`else
            if (!seen[i]) m_cnt[i] = 0;
            else if (tick) m_cnt[i] = (m_cnt[i] < PCM) ? m_cnt[i] + 1 : PCM;
            m_deb[i] = (m_cnt[i] == PCM);
`endif
        end
        m_rise = m_deb & ~prev;
        m_fall = ~m_deb & prev;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        n_asserts++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic step(input logic [W-1:0] v);
        glitchy_signal = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check("debounced", debounced_signal, m_deb);
        check("rise", rise_pulse, m_rise);
        check("fall", fall_pulse, m_fall);
        check("rise_and_fall", rise_pulse & fall_pulse, '0);
    endtask

    // Put the next edge one past a sample edge so a 10-cycle toggle burst sees its tick while low.
    task automatic align(input logic [W-1:0] v);
        while ((m_edges % SCM) != 0) step(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_deb"}, debounced_signal, '0);
        check({tag, "_rise"}, rise_pulse, '0);
        check({tag, "_fall"}, fall_pulse, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        int rem[W];
        logic [W-1:0] lvl;

        // Reset
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("reset");
        end
        rst_n = 1'b1;

        // Ch0 toggles, holds too briefly, then drops: must never assert
        align('0);
        for (int j = 0; j < 110; j++) begin
            if (j < 10) step({1'b0, (j % 2) == 0});
            else if (j < 50) step(2'b01);
            else step(2'b00);
            check("req029_deb0", {1'b0, debounced_signal[0]}, '0);
            check("req029_rise0", {1'b0, rise_pulse[0]}, '0);
        end

        // Ch1 toggles then holds high: set latency window and single rise pulse
        align('0);
        for (int j = 0; j < 10; j++) step({(j % 2) == 0, 1'b0});
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            step(2'b10);
            pulses += int'(rise_pulse[1]);
            if (debounced_signal[1]) lat = k;
        end
        check_range("req030_latency", lat, 43, 53);
        for (int k = 0; k < 30; k++) begin
            step(2'b10);
            pulses += int'(rise_pulse[1]);
            check("req030_hold", {debounced_signal[1], 1'b0}, 2'b10);
        end
        check_range("req030_rise_count", pulses, 1, 1);

`ifdef BUTTON_CONDITIONER_FALL_FILTER_EN
        // Short low glitch is absorbed, a sustained low releases
        for (int k = 0; k < 23; k++) begin
            step((k < 3) ? 2'b00 : 2'b10);
            check("req032_glitch_hold", {debounced_signal[1], 1'b0}, 2'b10);
        end
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            step(2'b00);
            pulses += int'(fall_pulse[1]);
            if (!debounced_signal[1]) lat = k;
        end
        check_range("req032_release_latency", lat, 1, 53);
        for (int k = 0; k < 20; k++) begin
            step(2'b00);
            pulses += int'(fall_pulse[1]);
            check("req032_low", {debounced_signal[1], 1'b0}, 2'b00);
        end
        check_range("req032_fall_count", pulses, 1, 1);
`else
        // Immediate release: low three cycles after the raw input falls
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            step(2'b00);
            pulses += int'(fall_pulse[1]);
            if (!debounced_signal[1]) lat = k;
        end
        check_range("req031_release_latency", lat, 3, 3);
        for (int k = 0; k < 60; k++) begin
            step(2'b00);
            pulses += int'(fall_pulse[1]);
            check("req031_low", {debounced_signal[1], 1'b0}, 2'b00);
        end
        check_range("req031_fall_count", pulses, 1, 1);
`endif

        // Saturate both, reset mid-operation, then full latency again on ch0
        for (int k = 0; k < 60; k++) step(2'b11);
        check("req033_saturated", debounced_signal, 2'b11);
        rst_n = 1'b0;
        #1;
        check_all_zero("req033_async_reset");
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("req033_in_reset");
        end
        glitchy_signal = 2'b01;
        rst_n = 1'b1;
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            step(2'b01);
            pulses += int'(rise_pulse[0]);
            if (debounced_signal[0]) lat = k;
        end
        check_range("req033_relatch_latency", lat, 43, 53);
        check_range("req033_rise_count", pulses, 1, 1);

        // Independent random patterns on both channels
        for (int i = 0; i < W; i++) rem[i] = 0;
        lvl = glitchy_signal;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(1, 70));
                end
                rem[i]--;
            end
            step(lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
